// File: rtl/mfp_ahb_wifi_frame_ctrl_pkg.sv
// Shared constants for the ESP Wi-Fi frame controller: register offsets,
// payload depth, parser state encodings and a saturating counter helper.
package mfp_ahb_wifi_frame_ctrl_pkg;

    localparam logic [3:0] H_WIFI_STATUS = 4'h0;
    localparam logic [3:0] H_WIFI_CMDLEN = 4'h4;
    localparam logic [3:0] H_WIFI_DATA   = 4'h8;
    localparam logic [3:0] H_WIFI_CTRL   = 4'hC;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;

    localparam int MFP_N_WIFI_PAYLOAD = 16;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4
    } wifi_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mfp_wifi_frame_parser.sv
// Byte-stream parser for SOF/CMD/LEN/payload/XOR frames; emits one-cycle events
// and a buffer write port. Inter-byte timeout built only with WIFI_FRAME_TIMEOUT_EN.
module mfp_wifi_frame_parser
    import mfp_ahb_wifi_frame_ctrl_pkg::*;
#(
    parameter int         MAX_PAYLOAD    = MFP_N_WIFI_PAYLOAD,
    parameter logic [7:0] SOF_BYTE       = 8'h7E,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic [7:0] byte_data,
    input  logic       byte_ready,
    input  logic       frame_valid,
    output logic       busy,
    output logic       commit,
    output logic       overrun_evt,
    output logic       err_evt,
    output logic [7:0] cmd_tmp,
    output logic [7:0] len_tmp,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data
);
    localparam logic [7:0] MAX8 = 8'(MAX_PAYLOAD);

    wifi_state_e state_q, state_d;
    logic       lock_q, lock_d;
    logic [7:0] chk_q, chk_d;
    logic [7:0] cmd_tmp_q, cmd_tmp_d;
    logic [7:0] len_tmp_q, len_tmp_d;
    logic [7:0] wr_ptr_q, wr_ptr_d;
    logic       timeout;

`ifdef WIFI_FRAME_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        timeout = 1'b0;
        if (byte_ready || state_q == ST_HUNT) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            cnt_d   = '0;
            timeout = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // State register; frame scratch registers carry no reset since HUNT re-initialises them.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_HUNT;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end

    always_ff @(posedge HCLK) begin
        chk_q     <= chk_d;
        cmd_tmp_q <= cmd_tmp_d;
        len_tmp_q <= len_tmp_d;
        wr_ptr_q  <= wr_ptr_d;
    end

    always_comb begin
        state_d   = state_q;
        lock_d    = lock_q;
        chk_d     = chk_q;
        cmd_tmp_d = cmd_tmp_q;
        len_tmp_d = len_tmp_q;
        wr_ptr_d  = wr_ptr_q;
        if (byte_ready) begin
            case (state_q)
                ST_HUNT: if (byte_data == SOF_BYTE) begin
                    lock_d  = frame_valid;
                    chk_d   = 8'h00;
                    state_d = ST_CMD;
                end
                ST_CMD: begin
                    cmd_tmp_d = byte_data;
                    chk_d     = chk_q ^ byte_data;
                    state_d   = ST_LEN;
                end
                ST_LEN: begin
                    if (byte_data > MAX8) begin
                        state_d = ST_HUNT;
                    end else begin
                        len_tmp_d = byte_data;
                        chk_d     = chk_q ^ byte_data;
                        wr_ptr_d  = 8'h00;
                        state_d   = (byte_data == 8'h00) ? ST_CHK : ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    chk_d    = chk_q ^ byte_data;
                    wr_ptr_d = wr_ptr_q + 8'd1;
                    if (wr_ptr_q + 8'd1 == len_tmp_q) state_d = ST_CHK;
                end
                default: state_d = ST_HUNT;
            endcase
        end else if (timeout) begin
            state_d = ST_HUNT;
        end
    end

    always_comb begin
        commit      = 1'b0;
        overrun_evt = 1'b0;
        err_evt     = timeout;
        wr_en       = 1'b0;
        if (byte_ready) begin
            case (state_q)
                ST_LEN:     err_evt = (byte_data > MAX8);
                ST_PAYLOAD: wr_en   = !lock_q;
                ST_CHK: begin
                    if (byte_data != chk_q) err_evt     = 1'b1;
                    else if (lock_q)        overrun_evt = 1'b1;
                    else                    commit      = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state_q != ST_HUNT);
    assign cmd_tmp = cmd_tmp_q;
    assign len_tmp = len_tmp_q;
    assign wr_addr = wr_ptr_q;
    assign wr_data = byte_data;

endmodule

// File: rtl/mfp_ahb_wifi_frame_ctrl.sv
// AHB-Lite slave for the ESP Wi-Fi UART frame path: registers, pop-on-read payload, IRQ.
// Optional inter-byte timeout: define WIFI_FRAME_TIMEOUT_EN.
module mfp_ahb_wifi_frame_ctrl
    import mfp_ahb_wifi_frame_ctrl_pkg::*;
#(
    parameter int         MAX_PAYLOAD    = MFP_N_WIFI_PAYLOAD,
    parameter logic [7:0] SOF_BYTE       = 8'h7E,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [3:0]  HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    input  logic        HSEL,
    output logic [31:0] HRDATA,
    input  logic [7:0]  byte_data,
    input  logic        byte_ready,
    output logic        frame_irq
);
    localparam int IDXW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

    logic [3:0]  addr_dly_q;
    logic        sel_dly_q, write_dly_q, trans_dly_q;
    logic        frame_valid_q, frame_valid_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        irq_en_q, irq_en_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  rd_ptr_q, rd_ptr_d;
    logic [31:0] hrdata_q, hrdata_d;
    logic [7:0]  buf_q [MAX_PAYLOAD];

    logic        busy, commit, overrun_evt, err_evt, wr_en;
    logic [7:0]  cmd_tmp, len_tmp, wr_addr, wr_data;
    logic        we, ack, clr, empty, pop;
    logic [7:0]  rd_byte;
    logic        unused_ok;

    mfp_wifi_frame_parser #(
        .MAX_PAYLOAD    (MAX_PAYLOAD),
        .SOF_BYTE       (SOF_BYTE),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_parser (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .frame_valid (frame_valid_q),
        .busy        (busy),
        .commit      (commit),
        .overrun_evt (overrun_evt),
        .err_evt     (err_evt),
        .cmd_tmp     (cmd_tmp),
        .len_tmp     (len_tmp),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    assign unused_ok = ^{HWDATA[31:3], wr_addr};

    always_comb begin
        we      = trans_dly_q && sel_dly_q && write_dly_q;
        ack     = we && (addr_dly_q == H_WIFI_CTRL) && HWDATA[0];
        clr     = we && (addr_dly_q == H_WIFI_CTRL) && HWDATA[1];
        empty   = (rd_ptr_q == len_q);
        pop     = HSEL && (HTRANS != HTRANS_IDLE) && !HWRITE && (HADDR == H_WIFI_DATA) && !empty;
        rd_byte = empty ? 8'h00 : buf_q[rd_ptr_q[IDXW-1:0]];

        irq_en_d = (we && addr_dly_q == H_WIFI_CTRL) ? HWDATA[2] : irq_en_q;
        // A same-cycle commit outranks ACK so a freshly completed frame is never lost.
        frame_valid_d = commit ? 1'b1 : (ack ? 1'b0 : frame_valid_q);
        rd_ptr_d      = (commit || ack) ? 8'h00 : (pop ? rd_ptr_q + 8'd1 : rd_ptr_q);
        cmd_d         = commit ? cmd_tmp : cmd_q;
        len_d         = commit ? len_tmp : len_q;
        overrun_d     = clr ? 1'b0 : (overrun_evt ? 1'b1 : overrun_q);
        err_cnt_d     = clr ? 8'h00 : (err_evt ? sat_inc8(err_cnt_q) : err_cnt_q);

        case (HADDR)
            H_WIFI_STATUS: hrdata_d = {16'h0, err_cnt_q, 5'b0, busy, overrun_q, frame_valid_q};
            H_WIFI_CMDLEN: hrdata_d = {16'h0, len_q, cmd_q};
            H_WIFI_DATA:   hrdata_d = {23'h0, empty, rd_byte};
            H_WIFI_CTRL:   hrdata_d = {29'h0, irq_en_q, 2'b00};
            default:       hrdata_d = 32'h0;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_dly_q    <= 4'h0;
            sel_dly_q     <= 1'b0;
            write_dly_q   <= 1'b0;
            trans_dly_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            err_cnt_q     <= 8'h00;
            irq_en_q      <= 1'b0;
            cmd_q         <= 8'h00;
            len_q         <= 8'h00;
            rd_ptr_q      <= 8'h00;
            hrdata_q      <= 32'h0;
        end else begin
            addr_dly_q    <= HADDR;
            sel_dly_q     <= HSEL;
            write_dly_q   <= HWRITE;
            trans_dly_q   <= (HTRANS != HTRANS_IDLE);
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
            err_cnt_q     <= err_cnt_d;
            irq_en_q      <= irq_en_d;
            cmd_q         <= cmd_d;
            len_q         <= len_d;
            rd_ptr_q      <= rd_ptr_d;
            hrdata_q      <= hrdata_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (wr_en) buf_q[wr_addr[IDXW-1:0]] <= wr_data;
    end

    assign HRDATA    = hrdata_q;
    assign frame_irq = frame_valid_q & irq_en_q;

endmodule

// File: tb/tb_mfp_ahb_wifi_frame_ctrl.sv
// Randomized bench for mfp_ahb_wifi_frame_ctrl against a frame-level reference model.
// Timeout expectations follow WIFI_FRAME_TIMEOUT_EN.
module tb_mfp_ahb_wifi_frame_ctrl;
    localparam int TMO = 200;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [3:0]  HADDR = 4'h0;
    logic [1:0]  HTRANS = 2'b00;
    logic [31:0] HWDATA = 32'h0;
    logic        HWRITE = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HRDATA;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready = 1'b0;
    logic        frame_irq;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: architectural state only.
    logic       m_valid = 0, m_ovr = 0, m_irq_en = 0, m_busy = 0;
    int         m_err = 0;
    logic [7:0] m_cmd = 0, m_len = 0;
    logic [7:0] m_pay[$];
    int         m_rd = 0;

    mfp_ahb_wifi_frame_ctrl #(
        .MAX_PAYLOAD    (16),
        .SOF_BYTE       (8'h7E),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWDATA     (HWDATA),
        .HWRITE     (HWRITE),
        .HSEL       (HSEL),
        .HRDATA     (HRDATA),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .frame_irq  (frame_irq)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #800000;
        $display("FAIL watchdog expired checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic ahb_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge HCLK); HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = a;
        @(negedge HCLK); HSEL = 0; HTRANS = 2'b00; d = HRDATA;
    endtask

    task automatic ahb_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge HCLK); HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = a;
        @(negedge HCLK); HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = d;
        @(negedge HCLK); HWDATA = 32'h0;
    endtask

    task automatic ctrl_write(input logic ack, input logic clr, input logic ien);
        ahb_write(4'hC, {29'h0, ien, clr, ack});
        if (ack) begin m_valid = 0; m_rd = 0; end
        if (clr) begin m_ovr = 0; m_err = 0; end
        m_irq_en = ien;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        @(negedge HCLK); byte_data = b; byte_ready = 1;
        @(negedge HCLK); byte_ready = 0;
        repeat ($urandom_range(0, max_gap)) @(negedge HCLK);
    endtask

    function automatic logic [31:0] exp_status();
        int e;
        e = (m_err > 255) ? 255 : m_err;
        return {16'h0, 8'(e), 5'b0, m_busy, m_ovr, m_valid};
    endfunction

    task automatic check_regs(input string tag);
        logic [31:0] d;
        check({tag, "_irq"}, {31'h0, frame_irq}, {31'h0, m_valid & m_irq_en});
        ahb_read(4'h0, d); check({tag, "_status"}, d, exp_status());
        ahb_read(4'h4, d); check({tag, "_cmdlen"}, d, {16'h0, m_len, m_cmd});
        ahb_read(4'hC, d); check({tag, "_ctrl"}, d, {29'h0, m_irq_en, 2'b00});
    endtask

    task automatic drain(input string tag, input int n);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            ahb_read(4'h8, d);
            if (m_rd < int'(m_len)) begin
                check({tag, "_data"}, d, {24'h0, m_pay[m_rd]});
                m_rd++;
            end else begin
                check({tag, "_empty"}, d, 32'h100);
            end
        end
    endtask

    // cmask != 0 corrupts the checksum byte by that XOR pattern.
    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] pay[$], input logic [7:0] cmask);
        logic [7:0] c;
        c = cmd ^ 8'(pay.size());
        foreach (pay[i]) c ^= pay[i];
        send_byte(8'h7E, 3);
        send_byte(cmd, 3);
        send_byte(8'(pay.size()), 3);
        foreach (pay[i]) send_byte(pay[i], 3);
        send_byte(c ^ cmask, 0);
        if (cmask != 0) m_err++;
        else if (m_valid) m_ovr = 1;
        else begin
            m_valid = 1; m_cmd = cmd; m_len = 8'(pay.size()); m_pay = pay; m_rd = 0;
        end
        check("frame_irq_latency", {31'h0, frame_irq}, {31'h0, m_valid & m_irq_en});
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  pq[$];
        logic [7:0]  b;
        int          act, n;

        #12;
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_irq", {31'h0, frame_irq}, 32'h0);
        repeat (3) @(negedge HCLK);
        HRESETn = 1;
        check_regs("reset");
        ahb_read(4'h1, d); check("odd_offset", d, 32'h0);

        ctrl_write(0, 0, 1);
        pq = {8'hAA, 8'hBB, 8'hCC};
        send_frame(8'h01, pq, 8'h00);
        check_regs("good");
        drain("good", 4);

        ctrl_write(1, 0, 1);
        send_frame(8'h01, pq, 8'hDF);
        check_regs("badchk");
        send_frame(8'h01, pq, 8'h00);
        check_regs("recover");

        pq = {8'h55};
        send_frame(8'h02, pq, 8'h00);
        check_regs("overrun");
        drain("overrun", 4);
        ctrl_write(1, 0, 1);
        check_regs("ack");
        ctrl_write(0, 1, 1);
        check_regs("clr");

        send_byte(8'h7E, 1); send_byte(8'h09, 1); send_byte(8'h20, 1);
        m_err++;
        check_regs("oversize");
        pq = {};
        send_frame(8'h05, pq, 8'h00);
        check_regs("zero_len");
        drain("zero_len", 1);
        ctrl_write(1, 0, 1);

        for (int it = 0; it < 60; it++) begin
            act = $urandom_range(0, 7);
            case (act)
                0, 1, 2: begin
                    pq = {};
                    n = $urandom_range(0, 16);
                    for (int i = 0; i < n; i++) pq.push_back(8'($urandom));
                    send_frame(8'($urandom), pq, (act == 2) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
                end
                3: begin
                    send_byte(8'h7E, 2); send_byte(8'($urandom), 2);
                    send_byte(8'($urandom_range(17, 255)), 2);
                    m_err++;
                end
                4: begin
                    n = $urandom_range(1, 4);
                    for (int i = 0; i < n; i++) begin
                        b = 8'($urandom);
                        if (b == 8'h7E) b = 8'h00;
                        send_byte(b, 2);
                    end
                end
                5: ctrl_write(1, 0, 1'($urandom));
                6: ctrl_write(0, 1, 1'($urandom));
                default: if (m_valid) drain("rand", $urandom_range(0, int'(m_len) - m_rd + 1));
            endcase
            check_regs("rand");
        end

        ctrl_write(1, 1, 0);
        send_byte(8'h7E, 0); send_byte(8'h01, 0);
        repeat (TMO + 10) @(negedge HCLK);
`ifdef WIFI_FRAME_TIMEOUT_EN
        m_err++;
        m_busy = 0;
`else
        m_busy = 1;
`endif
        check_regs("timeout");

        ctrl_write(0, 0, 1);
        send_byte(8'h7E, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        @(negedge HCLK); HRESETn = 0;
        @(negedge HCLK);
        check("midrst_hrdata", HRDATA, 32'h0);
        check("midrst_irq", {31'h0, frame_irq}, 32'h0);
        m_valid = 0; m_ovr = 0; m_irq_en = 0; m_busy = 0; m_err = 0;
        m_cmd = 0; m_len = 0; m_rd = 0;
        HRESETn = 1;
        send_byte(8'h33, 0); send_byte(8'h44, 0); send_byte(8'h43, 0);
        check_regs("midrst");
        drain("midrst", 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
